// File: rtl/i2c_pkg.sv
// Shared types, constants and bus-level decode for the I2C frame writer.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      BIT,
      ACK,
      STOP,
      DONE
   } state_e;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   localparam int         FRAME_BITS    = 24;
   localparam logic [7:0] WM8731_ADDR_W = 8'h34;

   // Returns {scl, sda_oe}; sda_oe=1 pulls SDA low, otherwise SDA is released.
   function automatic logic [1:0] bus_drive(input state_e st, input logic [1:0] q,
                                            input logic bit_val);
      logic scl;
      logic oe;
      scl = 1'b1;
      oe  = 1'b0;
      case (st)
         START:   oe = (q == Q2) || (q == Q3);
         BIT: begin
            scl = q[1];
            oe  = ~bit_val;
         end
         ACK:     scl = q[1];
         STOP: begin
            scl = q[1];
            oe  = (q != Q3);
         end
         default: ;
      endcase
      return {scl, oe};
   endfunction

   // Byte boundaries sit at bit index 16, 8, 0; bits [4:3] pick ack_err bit 2, 1, 0.
   function automatic logic [1:0] ack_slot(input logic [4:0] idx);
      return idx[4:3];
   endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-phase timebase: QDIV prescaler feeding a 2-bit quarter counter.
module i2c_phase_gen
   import i2c_pkg::*;
#(
   parameter int QDIV = 1
) (
   input  logic       clk_i2c,
   input  logic       reset_n,
   input  logic       run,
   input  logic       clear,
   output logic       tick,
   output logic [1:0] q
);

   localparam int            PW    = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam logic [PW-1:0] PLAST = PW'(QDIV - 1);

   logic [PW-1:0] phase;

   // tick marks the last clock of the current quarter
   assign tick = run && (phase == PLAST);

   always_ff @(posedge clk_i2c or negedge reset_n) begin
      if (!reset_n) begin
         phase <= '0;
         q     <= Q0;
      end else if (clear) begin
         phase <= '0;
         q     <= Q0;
      end else if (run) begin
         if (tick) begin
            phase <= '0;
            q     <= q + 2'd1;
         end else begin
            phase <= phase + PW'(1);
         end
      end
   end

endmodule

// File: rtl/i2c_frame_writer.sv
// I2C master write engine: one 24-bit frame per go/done handshake, with
// START, three ACKed bytes MSB-first and STOP; reports per-byte NACKs.
module i2c_frame_writer
   import i2c_pkg::*;
#(
   parameter int QDIV = 1
) (
   input  logic        clk_i2c,
   input  logic        reset_n,
   input  logic [23:0] i2c_data,
   input  logic        go,
   output logic        done,
   output logic        busy,
   output logic [2:0]  ack_err,
   output logic        I2C_SCLK,
   inout  wire         I2C_SDAT
);

   state_e                state;
   state_e                state_n;
   logic [FRAME_BITS-1:0] frame;
   logic [FRAME_BITS-1:0] frame_n;
   logic [4:0]            bit_idx;
   logic [4:0]            idx_n;
   logic [2:0]            ack_n;
   logic                  busy_n;
   logic                  done_n;
   logic                  scl_n;
   logic                  sda_oe;
   logic                  sda_oe_n;
   logic                  run;
   logic                  tick;
   logic                  qend;
   logic                  sda_in;
   logic [1:0]            q;
   logic [1:0]            q_nx;

   assign run    = (state != IDLE) && (state != DONE);
   assign qend   = tick && (q == Q3);
   assign q_nx   = tick ? q + 2'd1 : q;
   assign sda_in = I2C_SDAT;

   assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;

   i2c_phase_gen #(.QDIV(QDIV)) u_phase (
      .clk_i2c (clk_i2c),
      .reset_n (reset_n),
      .run     (run),
      .clear   (~run),
      .tick    (tick),
      .q       (q)
   );

   // go/done handshake: go is a level request sampled only in IDLE; done rises on
   // entering DONE while go is still high and falls on the edge that sees go low.
   always_comb begin
      state_n = state;
      frame_n = frame;
      idx_n   = bit_idx;
      ack_n   = ack_err;
      busy_n  = busy;
      done_n  = done;
      case (state)
         IDLE: begin
            if (go) begin
               frame_n = i2c_data;
               ack_n   = 3'b000;
               busy_n  = 1'b1;
               idx_n   = 5'd23;
               state_n = START;
            end
         end
         START: begin
            if (qend) state_n = BIT;
         end
         BIT: begin
            if (qend) begin
               if ((bit_idx == 5'd16) || (bit_idx == 5'd8) || (bit_idx == 5'd0)) begin
                  state_n = ACK;
               end else begin
                  idx_n = bit_idx - 5'd1;
               end
            end
         end
         ACK: begin
            // sample on the last clock of q2, mid SCL-high
            if (tick && (q == Q2) && (sda_in == 1'b1)) ack_n[ack_slot(bit_idx)] = 1'b1;
            if (qend) begin
               if (bit_idx == 5'd0) begin
                  state_n = STOP;
               end else begin
                  idx_n   = bit_idx - 5'd1;
                  state_n = BIT;
               end
            end
         end
         STOP: begin
            if (qend) begin
               state_n = DONE;
               busy_n  = 1'b0;
               done_n  = go;
            end
         end
         DONE: begin
            if (!go) begin
               done_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      // bus pins are registered from the state being entered so they line up with it
      {scl_n, sda_oe_n} = bus_drive(state_n, q_nx, frame_n[idx_n]);
   end

   always_ff @(posedge clk_i2c or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         frame    <= '0;
         bit_idx  <= '0;
         ack_err  <= 3'b000;
         busy     <= 1'b0;
         done     <= 1'b0;
         I2C_SCLK <= 1'b1;
         sda_oe   <= 1'b0;
      end else begin
         state    <= state_n;
         frame    <= frame_n;
         bit_idx  <= idx_n;
         ack_err  <= ack_n;
         busy     <= busy_n;
         done     <= done_n;
         I2C_SCLK <= scl_n;
         sda_oe   <= sda_oe_n;
      end
   end

endmodule

// File: tb/tb_i2c_frame_writer.sv
// Bench for i2c_frame_writer: a QDIV=1 and a QDIV=4 instance share one slave
// model and scoreboard; sel picks which instance is exercised.
module tb_i2c_frame_writer;
   import i2c_pkg::*;

   localparam int RW     = 20;  // {done, ack_err[2:0], busy cycles[15:0]}
   localparam int BUDGET = 1000;

   logic clk_i2c = 1'b0;
   always #5 clk_i2c = ~clk_i2c;

   logic        reset_n;
   logic        go;
   logic        sel;
   logic [23:0] i2c_data;
   logic        done_a, busy_a, scl_a, done_b, busy_b, scl_b;
   logic [2:0]  ack_a, ack_b;
   wire         sda_a;
   wire         sda_b;
   logic        slave_pull;
   logic        slave_present;
   logic [2:0]  slave_mask;

   pullup (sda_a);
   pullup (sda_b);
   assign sda_a = (slave_pull && !sel) ? 1'b0 : 1'bz;
   assign sda_b = (slave_pull && sel) ? 1'b0 : 1'bz;

   i2c_frame_writer #(.QDIV(1)) dut_a (
      .clk_i2c(clk_i2c), .reset_n(reset_n), .i2c_data(i2c_data), .go(go && !sel),
      .done(done_a), .busy(busy_a), .ack_err(ack_a), .I2C_SCLK(scl_a), .I2C_SDAT(sda_a)
   );

   i2c_frame_writer #(.QDIV(4)) dut_b (
      .clk_i2c(clk_i2c), .reset_n(reset_n), .i2c_data(i2c_data), .go(go && sel),
      .done(done_b), .busy(busy_b), .ack_err(ack_b), .I2C_SCLK(scl_b), .I2C_SDAT(sda_b)
   );

   logic       done_m, busy_m, scl_m, sda_m;
   logic [2:0] ack_m;
   int         qdiv_m;
   assign done_m = sel ? done_b : done_a;
   assign busy_m = sel ? busy_b : busy_a;
   assign scl_m  = sel ? scl_b : scl_a;
   assign sda_m  = sel ? sda_b : sda_a;
   assign ack_m  = sel ? ack_b : ack_a;
   assign qdiv_m = sel ? 4 : 1;

   // ---------------- scoreboard ----------------
   logic [RW-1:0] exp_q[$];
   logic [7:0]    exp_byte_q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;

   always @(posedge clk_i2c) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_unexpected(input string name, input int act);
      checks++;
      errors++;
      $display("FAIL %s actual=%0h expected=nothing t=%0t", name, act, $time);
   endtask

   // ---------------- slave model ----------------
   logic       scl_p = 1'b1, sda_p = 1'b1;
   logic       in_frame = 1'b0, ack_phase = 1'b0, rise_seen = 1'b0;
   int         nbits = 0, nbytes = 0, last_rise = 0;
   logic [7:0] shreg = 8'h00;

   initial slave_pull = 1'b0;

   always @(negedge clk_i2c) begin
      if (!reset_n) begin
         in_frame   = 1'b0;
         ack_phase  = 1'b0;
         rise_seen  = 1'b0;
         slave_pull = 1'b0;
         nbits      = 0;
         nbytes     = 0;
      end else if (scl_p && scl_m && (sda_p != sda_m)) begin
         if (!sda_m) begin
            check("start_outside_frame", in_frame, 0);
            in_frame  = 1'b1;
            ack_phase = 1'b0;
            rise_seen = 1'b0;
            nbits     = 0;
            nbytes    = 0;
         end else if (in_frame) begin
            check("stop_byte_count", nbytes, 3);
            in_frame = 1'b0;
         end
      end else if (in_frame && !scl_p && scl_m) begin
         if (rise_seen) check("scl_period", cyc - last_rise, 4 * qdiv_m);
         rise_seen = 1'b1;
         last_rise = cyc;
         if (!ack_phase && nbytes < 3 && nbits < 8) begin
            shreg = {shreg[6:0], sda_m};
            nbits++;
            if (nbits == 8) begin
               if (exp_byte_q.size() == 0) check_unexpected("byte_extra", shreg);
               else check("byte_value", shreg, exp_byte_q.pop_front());
            end
         end
      end else if (in_frame && scl_p && !scl_m) begin
         if (ack_phase) begin
            ack_phase  = 1'b0;
            slave_pull = 1'b0;
            nbits      = 0;
            nbytes++;
         end else if (nbits == 8) begin
            ack_phase  = 1'b1;
            slave_pull = slave_present && slave_mask[2-nbytes];
         end
      end
      scl_p = scl_m;
      sda_p = sda_m;
   end

   // ---------------- response monitor ----------------
   logic          busy_p = 1'b0;
   int            t_start = 0;
   logic [RW-1:0] exp_r;

   always @(negedge clk_i2c) begin
      if (!reset_n) begin
         busy_p = 1'b0;
      end else begin
         if (!busy_p && busy_m) t_start = cyc;
         if (busy_p && !busy_m) begin
            if (exp_q.size() == 0) begin
               check_unexpected("resp_extra", {done_m, ack_m});
            end else begin
               exp_r = exp_q.pop_front();
               check("resp_done", done_m, exp_r[19]);
               check("resp_ack_err", ack_m, exp_r[18:16]);
               check("resp_latency", cyc - t_start, exp_r[15:0]);
            end
         end
         busy_p = busy_m;
      end
   end

   // ---------------- drivers ----------------
   task automatic run_frame(input logic [23:0] d, input logic [2:0] mask, input logic present,
                            input logic hold_go, input logic change_data);
      logic [2:0] exp_ack;
      exp_ack = present ? ~mask : 3'b111;
      @(negedge clk_i2c);
      i2c_data      = d;
      slave_mask    = mask;
      slave_present = present;
      exp_byte_q.push_back(d[23:16]);
      exp_byte_q.push_back(d[15:8]);
      exp_byte_q.push_back(d[7:0]);
      exp_q.push_back({hold_go, exp_ack, 16'(116 * qdiv_m)});
      go = 1'b1;
      for (int n = 0; n < BUDGET; n++) begin
         @(negedge clk_i2c);
         if (change_data && n == 20) i2c_data = ~d;
         if (!hold_go && n == 10) go = 1'b0;
         if (!busy_m) break;
      end
      check("busy_end", busy_m, 0);
      if (hold_go) begin
         check("done_set", done_m, 1);
         go = 1'b0;
         @(negedge clk_i2c);
         check("done_clear", done_m, 0);
      end else begin
         @(negedge clk_i2c);
         check("done_skipped", done_m, 0);
      end
      check("ack_err_hold", ack_m, exp_ack);
   endtask

   task automatic reset_mid_byte1();
      @(negedge clk_i2c);
      i2c_data      = 24'h34_55_AA;
      slave_mask    = 3'b111;
      slave_present = 1'b0;
      exp_byte_q.push_back(8'h34);
      go = 1'b1;
      repeat (55) @(negedge clk_i2c);
      check("mid_busy", busy_m, 1);
      check("mid_ack_err", ack_m, 3'b100);
      #2 reset_n = 1'b0;
      go = 1'b0;
      #1;
      check("rst_scl", scl_m, 1);
      check("rst_sda", sda_m, 1);
      check("rst_busy", busy_m, 0);
      check("rst_done", done_m, 0);
      check("rst_ack_err", ack_m, 0);
      repeat (3) @(negedge clk_i2c);
      reset_n = 1'b1;
   endtask

   logic [23:0] chain_d [9] = '{24'h34_1E_00, 24'h34_00_17, 24'h34_02_17, 24'h34_04_79,
                                24'h34_06_79, 24'h34_08_15, 24'h34_0A_00, 24'h34_0C_00,
                                24'h34_0E_42};
   logic [2:0]  chain_m [9] = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011,
                                3'b111, 3'b000};

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n       = 1'b1;
      go            = 1'b0;
      sel           = 1'b0;
      i2c_data      = 24'h0;
      slave_present = 1'b1;
      slave_mask    = 3'b111;
      #2 reset_n = 1'b0;
      #1;
      check("init_scl_a", scl_a, 1);
      check("init_sda_a", sda_a, 1);
      check("init_busy_a", busy_a, 0);
      check("init_done_a", done_a, 0);
      check("init_ack_a", ack_a, 0);
      check("init_scl_b", scl_b, 1);
      check("init_busy_b", busy_b, 0);
      repeat (3) @(negedge clk_i2c);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_i2c);

      run_frame({WM8731_ADDR_W, 8'h1E, 8'h00}, 3'b111, 1'b1, 1'b1, 1'b0);
      run_frame(24'h34_07_5A, 3'b111, 1'b0, 1'b1, 1'b0);
      run_frame(24'h34_0C_9F, 3'b110, 1'b1, 1'b1, 1'b0);
      run_frame(24'h34_08_15, 3'b111, 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk_i2c);

      for (int i = 0; i < 9; i++) run_frame(chain_d[i], chain_m[i], 1'b1, 1'b1, 1'b0);

      reset_mid_byte1();
      run_frame(24'h34_12_34, 3'b111, 1'b1, 1'b1, 1'b0);

      @(negedge clk_i2c);
      sel = 1'b1;
      run_frame(24'h34_04_11, 3'b111, 1'b1, 1'b1, 1'b1);
      run_frame(24'h34_A5_C3, 3'b010, 1'b1, 1'b1, 1'b1);

      repeat (4) @(negedge clk_i2c);
      check("resp_queue_empty", exp_q.size(), 0);
      check("byte_queue_empty", exp_byte_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
